// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and saturation helper for the pipelined adder
package adder_pkg;

    localparam int ARCH_SYNTH = 0;
    localparam int ARCH_RCA   = 1;

    localparam int SAT_WRAP = 0;
    localparam int SAT_SAT  = 1;

    localparam int SAT_MAX_W = 1024;

    // Positive overflow wraps to a negative raw result (msb=1), so msb=1 selects MAX.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input logic msb, input int unsigned width);
        logic [SAT_MAX_W-1:0] w_min;
        w_min = SAT_MAX_W'(1) << (width - 1);
        return msb ? (w_min - SAT_MAX_W'(1)) : w_min;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result stream bundle between producer, adder and consumer
interface pipelined_adder_if #(
    parameter int PARALLELISM = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [PARALLELISM-1:0] add1;
    logic [PARALLELISM-1:0] add0;
    logic                   carry_in;
    logic                   op_sub;
    logic                   out_valid;
    logic                   out_ready;
    logic [PARALLELISM-1:0] sum;
    logic                   carry_out;
    logic                   overflow;

    modport master (
        output in_valid, add1, add0, carry_in, op_sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, add1, add0, carry_in, op_sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/adder_segment.sv
// rtl/adder_segment.sv - combinational W-bit adder slice exposing carry out and carry into its top bit
module adder_segment
    import adder_pkg::*;
#(
    parameter int W         = 8,
    parameter int ARCH_TYPE = ARCH_SYNTH
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co,
    output logic         o_c_msb
);

    generate
        if (ARCH_TYPE == ARCH_RCA) begin : g_rca
            logic [W:0] w_c;

            always_comb begin
                w_c    = '0;
                w_c[0] = i_ci;
                for (int i = 0; i < W; i++) begin
                    w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
                end
            end

            assign o_s     = i_a ^ i_b ^ w_c[W-1:0];
            assign o_co    = w_c[W];
            assign o_c_msb = w_c[W-1];
        end else begin : g_synth
            logic [W:0] w_full;

            assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};
            assign o_s     = w_full[W-1:0];
            assign o_co    = w_full[W];
            // Carry into the top bit recovered from its sum bit.
            assign o_c_msb = i_a[W-1] ^ i_b[W-1] ^ w_full[W-1];
        end
    endgenerate

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - segmented, valid/ready pipelined signed add/sub with overflow and optional saturation
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int PARALLELISM = 32,
    parameter int STAGES      = 4,
    parameter int SAT_MODE    = SAT_WRAP,
    parameter int ARCH_TYPE   = ARCH_SYNTH
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);

    localparam int P   = PARALLELISM;
    localparam int SEG = PARALLELISM / STAGES;

    generate
        if (P < 2 || STAGES < 1 || STAGES > P || (P % STAGES) != 0 || P > SAT_MAX_W) begin : g_bad_params
            $error("pipelined_adder: PARALLELISM must be >= 2 and a multiple of STAGES");
        end
    endgenerate

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [P-1:0]      r_a [STAGES];
    logic [P-1:0]      r_b [STAGES];
    logic [P-1:0]      r_s [STAGES];
    logic              r_ovf;

    logic [STAGES:0]   w_ld;
    logic [STAGES-1:0] w_v_in;
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_co;
    logic              w_c_msb [STAGES];
    logic [P-1:0]      w_a_in  [STAGES];
    logic [P-1:0]      w_b_in  [STAGES];
    logic [P-1:0]      w_s_in  [STAGES];
    logic [P-1:0]      w_s_out [STAGES];
    logic [SEG-1:0]    w_seg   [STAGES];
    logic              w_ovf;
    logic [P-1:0]      w_sum_fin;

    // Load chain runs from the output back to the input, so a drain frees every stage behind it.
    always_comb begin
        w_ld         = '0;
        w_ld[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_ld[k] = ~r_v[k] | w_ld[k+1];
        end
    end

    assign bus.in_ready = w_ld[0];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign w_v_in[0] = bus.in_valid;
                assign w_a_in[0] = bus.add1;
                assign w_b_in[0] = bus.op_sub ? ~bus.add0 : bus.add0;
                assign w_c_in[0] = bus.op_sub ^ bus.carry_in;
                assign w_s_in[0] = '0;
            end else begin : g_next
                assign w_v_in[k] = r_v[k-1];
                assign w_a_in[k] = r_a[k-1];
                assign w_b_in[k] = r_b[k-1];
                assign w_c_in[k] = r_c[k-1];
                assign w_s_in[k] = r_s[k-1];
            end

            adder_segment #(
                .W         (SEG),
                .ARCH_TYPE (ARCH_TYPE)
            ) u_seg (
                .i_a     (w_a_in[k][k*SEG +: SEG]),
                .i_b     (w_b_in[k][k*SEG +: SEG]),
                .i_ci    (w_c_in[k]),
                .o_s     (w_seg[k]),
                .o_co    (w_co[k]),
                .o_c_msb (w_c_msb[k])
            );

            // Bits above this segment are still zero, so OR-ing in the new slice is exact.
            assign w_s_out[k] = w_s_in[k] | (P'(w_seg[k]) << (k * SEG));
        end
    endgenerate

    assign w_ovf     = w_c_msb[STAGES-1] ^ w_co[STAGES-1];
    assign w_sum_fin = (SAT_MODE == SAT_SAT && w_ovf) ? P'(sat_value(w_s_out[STAGES-1][P-1], P))
                                                      : w_s_out[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ld[k]) begin
                    r_v[k] <= w_v_in[k];
                    if (w_v_in[k]) begin
                        r_a[k] <= w_a_in[k];
                        r_b[k] <= w_b_in[k];
                        r_c[k] <= w_co[k];
                        r_s[k] <= (k == STAGES - 1) ? w_sum_fin : w_s_out[k];
                    end
                end
            end
            if (w_ld[STAGES-1] && w_v_in[STAGES-1]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign bus.out_valid = r_v[STAGES-1];
    assign bus.sum       = r_s[STAGES-1];
    assign bus.carry_out = r_c[STAGES-1];
    assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and randomized checks of pipelined_adder across stage/arch/saturation configurations
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int P    = 32;
    localparam int NDUT = 12;
    localparam int MAIN = 1;
    localparam int SATI = 7;

    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ov;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        carry_in = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_ready = 1'b0;
    logic        chk_empty = 1'b0;
    logic [31:0] add1 = '0;
    logic [31:0] add0 = '0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sub, input int sat);
        longint sa, sb, ua, ub, lci, tr;
        res_t   r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        lci = ci ? 1 : 0;
        tr  = sub ? (sa - sb - lci) : (sa + sb + lci);
        r.ov  = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
        r.co  = sub ? (ua >= ub + lci) : (ua + ub + lci > 64'sd4294967295);
        r.sum = (sat == 1 && r.ov) ? ((tr > 0) ? 32'h7FFFFFFF : 32'h80000000) : tr[31:0];
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int S  = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 4 : 32);
            localparam int A  = (gi / 3) % 2;
            localparam int SM = gi / 6;

            pipelined_adder_if #(.PARALLELISM(P)) u_if ();

            assign u_if.in_valid  = in_valid;
            assign u_if.add1      = add1;
            assign u_if.add0      = add0;
            assign u_if.carry_in  = carry_in;
            assign u_if.op_sub    = op_sub;
            assign u_if.out_ready = out_ready;

            pipelined_adder #(
                .PARALLELISM (P),
                .STAGES      (S),
                .SAT_MODE    (SM),
                .ARCH_TYPE   (A)
            ) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (u_if)
            );

            res_t q[$];

            always @(negedge clk) begin
                if (!rst_n) begin
                    q.delete();
                end else begin
                    if (u_if.out_valid && out_ready) begin
                        chk($sformatf("sb%0d_nonempty", gi), 64'(q.size() > 0), 64'd1);
                        if (q.size() > 0)
                            chk($sformatf("sb%0d_result", gi),
                                64'({u_if.sum, u_if.carry_out, u_if.overflow}), 64'(q.pop_front()));
                    end
                    if (in_valid && u_if.in_ready)
                        q.push_back(model(add1, add0, carry_in, op_sub, SM));
                    if (chk_empty)
                        chk($sformatf("sb%0d_drained", gi), 64'(q.size()), 64'd0);
                end
            end
        end
    endgenerate

    wire        m_in_ready  = g_dut[MAIN].u_if.in_ready;
    wire        m_out_valid = g_dut[MAIN].u_if.out_valid;
    wire [31:0] m_sum       = g_dut[MAIN].u_if.sum;
    wire        m_co        = g_dut[MAIN].u_if.carry_out;
    wire        m_ov        = g_dut[MAIN].u_if.overflow;
    wire [31:0] s_sum       = g_dut[SATI].u_if.sum;
    wire        s_ov        = g_dut[SATI].u_if.overflow;

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sub,
                         input logic [31:0] es, input logic eco, input logic eov,
                         input logic [31:0] esat, input string tag);
        @(posedge clk); #1;
        add1 = a; add0 = b; carry_in = ci; op_sub = sub; in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, m_in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) chk({tag, "_early_valid"}, m_out_valid, 0);
        end
        chk({tag, "_out_valid"}, m_out_valid, 1);
        chk({tag, "_sum"}, m_sum, es);
        chk({tag, "_carry_out"}, m_co, eco);
        chk({tag, "_overflow"}, m_ov, eov);
        chk({tag, "_sat_sum"}, s_sum, esat);
        chk({tag, "_sat_overflow"}, s_ov, eov);
    endtask

    initial begin
        int          sent;
        int          rx;
        logic        saw_nr;
        logic        stall_prev;
        logic [33:0] prev;

        out_ready = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", m_out_valid, 0);
        chk("reset_sum", m_sum, 0);
        chk("reset_carry_out", m_co, 0);
        chk("reset_overflow", m_ov, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", m_in_ready, 1);

        do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 32'h00000100, "t1_seg_carry");
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000000, "t2_full_ripple");
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 32'h7FFFFFFF, "t3_pos_ovf");
        do_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 32'h80000000, "t3_neg_ovf");

        sent = 0; rx = 0; saw_nr = 1'b0; stall_prev = 1'b0; prev = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 3 && c <= 8);
            in_valid  = (sent < 10);
            add1 = 32'(sent); add0 = 32'h100; carry_in = 1'b0; op_sub = 1'b0;
            @(negedge clk);
            if (stall_prev) chk("t4_hold_stable", {m_sum, m_co, m_ov}, prev);
            stall_prev = m_out_valid && !out_ready;
            prev = {m_sum, m_co, m_ov};
            if (m_out_valid && out_ready) begin
                chk("t4_order", m_sum, 32'h100 + 32'(rx));
                rx++;
            end
            if (!m_in_ready) saw_nr = 1'b1;
            if (in_valid && m_in_ready) sent++;
        end
        chk("t4_result_count", rx, 10);
        chk("t4_in_ready_fell", saw_nr, 1);

        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; add1 = 32'h7FFFFFFF; add0 = 32'(c + 1); carry_in = 1'b1; op_sub = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", m_out_valid, 0);
        chk("t5_rst_sum", m_sum, 0);
        chk("t5_rst_carry_out", m_co, 0);
        chk("t5_rst_overflow", m_ov, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t5_no_stale_valid", m_out_valid, 0);
        end
        do_op(32'h12345678, 32'h00000008, 1'b1, 1'b1, 32'h1234566F, 1'b1, 1'b0, 32'h1234566F, "t5_after_reset");

        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            add1      = pick();
            add0      = pick();
            carry_in  = 1'($urandom_range(0, 1));
            op_sub    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk_empty = 1'b1;
        @(posedge clk); #1;
        chk_empty = 1'b0;

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
